// File: rtl/y86_pkg.sv
// ============================================================================
//  y86_pkg
//  Shared Y86 constants and memory-stage state type.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package y86_pkg;

  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] SAOK = 4'h1;
  localparam logic [3:0] SHLT = 4'h2;
  localparam logic [3:0] SADR = 4'h3;
  localparam logic [3:0] SINS = 4'h4;

  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_DONE = 2'd2
  } mem_state_e;

  function automatic logic is_mem_read(input logic [3:0] icode);
    return (icode == IMRMOVQ) || (icode == IPOPQ) || (icode == IRET);
  endfunction

  function automatic logic is_mem_write(input logic [3:0] icode);
    return (icode == IRMMOVQ) || (icode == IPUSHQ) || (icode == ICALL);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_array.sv
// ============================================================================
//  dmem_array
//  DEPTH x WORD_W data memory, one synchronous write port, one async read port.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_array #(
  parameter int WORD_W = 64,
  parameter int DEPTH  = 1024,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);

  localparam logic [AW:0] DEPTH_V = (AW + 1)'(DEPTH);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Non-power-of-two depths leave holes in the index space; read them as zero.
  assign rdata = ({1'b0, raddr} < DEPTH_V) ? mem[raddr] : '0;

endmodule

`default_nettype wire

// File: rtl/pipe_mem_stage.sv
// ============================================================================
//  pipe_mem_stage
//  Y86 memory stage with configurable access latency and the W pipeline register.
//  Optional stall counter port enabled by PIPE_MEM_PERF_EN.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_mem_stage
  import y86_pkg::*;
#(
  parameter int WORD_W  = 64,
  parameter int DEPTH   = 1024,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        M_stat,
  input  logic [3:0]        M_icode,
  input  logic [WORD_W-1:0] M_valE,
  input  logic [WORD_W-1:0] M_valA,
  input  logic [3:0]        M_dstE,
  input  logic [3:0]        M_dstM,
  input  logic              W_stall,
  input  logic              W_bubble,
  output logic [3:0]        m_stat,
  output logic [WORD_W-1:0] m_valM,
  output logic              m_busy,
  output logic [3:0]        W_stat,
  output logic [3:0]        W_icode,
  output logic [WORD_W-1:0] W_valE,
  output logic [WORD_W-1:0] W_valM,
  output logic [3:0]        W_dstE,
  output logic [3:0]        W_dstM
`ifdef PIPE_MEM_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT + 1) : 1;
  localparam logic [CW-1:0]     LAT_V     = CW'(MEM_LAT);
  localparam logic [WORD_W-3:0] DEPTH_IDX = (WORD_W - 2)'(DEPTH);

  logic              rd_op, wr_op, mem_op, dmem_error;
  logic [WORD_W-1:0] addr;
  logic [WORD_W-4:0] word_idx;
  logic [WORD_W-1:0] rd_data;
  logic              mem_we, w_load, start;

  mem_state_e        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;

  logic [3:0]        w_stat_q, w_stat_d, w_icode_q, w_icode_d;
  logic [WORD_W-1:0] w_vale_q, w_vale_d, w_valm_q, w_valm_d;
  logic [3:0]        w_dste_q, w_dste_d, w_dstm_q, w_dstm_d;

  always_comb begin
    rd_op  = is_mem_read(M_icode);
    wr_op  = is_mem_write(M_icode);
    mem_op = rd_op | wr_op;
    addr   = ((M_icode == IPOPQ) || (M_icode == IRET)) ? M_valA : M_valE;
  end

  assign word_idx   = addr[WORD_W-1:3];
  assign dmem_error = mem_op && ((addr[2:0] != 3'b000) || ({1'b0, word_idx} >= DEPTH_IDX));
  assign start      = (MEM_LAT > 0) && !rst && mem_op && !dmem_error;
  assign w_load     = !rst && !W_bubble && !W_stall && !m_busy;

  // The store lands only on the edge that moves the instruction into W.
  assign mem_we = wr_op && !dmem_error && w_load && ((MEM_LAT == 0) || (state_q == MEM_DONE));

  dmem_array #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_dmem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (word_idx[AW-1:0]),
    .wdata (M_valA),
    .raddr (word_idx[AW-1:0]),
    .rdata (rd_data)
  );

  // The issue cycle counts as the first busy cycle, so WAIT exits once the
  // decremented count reaches 1, giving exactly MEM_LAT busy cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    m_busy  = 1'b0;
    case (state_q)
      MEM_IDLE: begin
        if (start) begin
          m_busy = 1'b1;
          cnt_d  = LAT_V;
          if (MEM_LAT == 1) begin
            state_d = MEM_DONE;
            rdata_d = rd_data;
          end else begin
            state_d = MEM_WAIT;
          end
        end
      end
      MEM_WAIT: begin
        m_busy = 1'b1;
        cnt_d  = cnt_q - CW'(1);
        if ({1'b0, cnt_q} <= (CW + 1)'(2)) begin
          state_d = MEM_DONE;
          rdata_d = rd_data;
        end
      end
      MEM_DONE: begin
        cnt_d = '0;
        if (!W_stall) begin
          state_d = MEM_IDLE;
        end
      end
      default: state_d = MEM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MEM_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    m_stat = dmem_error ? SADR : M_stat;
    m_valM = '0;
    if (rd_op && !dmem_error) begin
      m_valM = (state_q == MEM_DONE) ? rdata_q : rd_data;
    end
  end

  always_comb begin
    w_stat_d  = w_stat_q;
    w_icode_d = w_icode_q;
    w_vale_d  = w_vale_q;
    w_valm_d  = w_valm_q;
    w_dste_d  = w_dste_q;
    w_dstm_d  = w_dstm_q;
    if (W_bubble || (!W_stall && m_busy)) begin
      w_stat_d  = SAOK;
      w_icode_d = INOP;
      w_vale_d  = '0;
      w_valm_d  = '0;
      w_dste_d  = RNONE;
      w_dstm_d  = RNONE;
    end else if (!W_stall) begin
      w_stat_d  = m_stat;
      w_icode_d = M_icode;
      w_vale_d  = M_valE;
      w_valm_d  = m_valM;
      w_dste_d  = M_dstE;
      w_dstm_d  = M_dstM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_stat_q  <= SAOK;
      w_icode_q <= INOP;
      w_vale_q  <= '0;
      w_valm_q  <= '0;
      w_dste_q  <= RNONE;
      w_dstm_q  <= RNONE;
    end else begin
      w_stat_q  <= w_stat_d;
      w_icode_q <= w_icode_d;
      w_vale_q  <= w_vale_d;
      w_valm_q  <= w_valm_d;
      w_dste_q  <= w_dste_d;
      w_dstm_q  <= w_dstm_d;
    end
  end

  assign W_stat  = w_stat_q;
  assign W_icode = w_icode_q;
  assign W_valE  = w_vale_q;
  assign W_valM  = w_valm_q;
  assign W_dstE  = w_dste_q;
  assign W_dstM  = w_dstm_q;

`ifdef PIPE_MEM_PERF_EN
  logic [31:0] perf_cnt_q, perf_cnt_d;

  always_comb begin
    perf_cnt_d = perf_cnt_q;
    if (m_busy && (perf_cnt_q != 32'hFFFF_FFFF)) begin
      perf_cnt_d = perf_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cnt_q <= '0;
    end else begin
      perf_cnt_q <= perf_cnt_d;
    end
  end

  assign perf_stall_cnt = perf_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_mem_stage.sv
// ============================================================================
//  tb_pipe_mem_stage
//  Directed bench: one single-cycle instance and one two-cycle-latency instance.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_mem_stage;
  import y86_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  M_stat, M_icode, M_dstE, M_dstM;
  logic [63:0] M_valE, M_valA;
  logic        W_stall, W_bubble;

  logic [3:0]  m_stat0, W_stat0, W_icode0, W_dstE0, W_dstM0;
  logic [63:0] m_valM0, W_valE0, W_valM0;
  logic        m_busy0;
  logic [3:0]  m_stat2, W_stat2, W_icode2, W_dstE2, W_dstM2;
  logic [63:0] m_valM2, W_valE2, W_valM2;
  logic        m_busy2;
`ifdef PIPE_MEM_PERF_EN
  logic [31:0] perf0, perf2;
`endif

  logic        sel;
  logic        busy_s;
  logic [3:0]  mstat_s, wstat_s, wicode_s, wdstm_s;
  logic [63:0] mvalm_s, wvale_s, wvalm_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_mem_stage #(.WORD_W(64), .DEPTH(1024), .MEM_LAT(0)) u_dut0 (
    .clk(clk), .rst(rst), .M_stat(M_stat), .M_icode(M_icode), .M_valE(M_valE),
    .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM), .W_stall(W_stall),
    .W_bubble(W_bubble), .m_stat(m_stat0), .m_valM(m_valM0), .m_busy(m_busy0),
    .W_stat(W_stat0), .W_icode(W_icode0), .W_valE(W_valE0), .W_valM(W_valM0),
    .W_dstE(W_dstE0), .W_dstM(W_dstM0)
`ifdef PIPE_MEM_PERF_EN
    , .perf_stall_cnt(perf0)
`endif
  );

  pipe_mem_stage #(.WORD_W(64), .DEPTH(1024), .MEM_LAT(2)) u_dut2 (
    .clk(clk), .rst(rst), .M_stat(M_stat), .M_icode(M_icode), .M_valE(M_valE),
    .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM), .W_stall(W_stall),
    .W_bubble(W_bubble), .m_stat(m_stat2), .m_valM(m_valM2), .m_busy(m_busy2),
    .W_stat(W_stat2), .W_icode(W_icode2), .W_valE(W_valE2), .W_valM(W_valM2),
    .W_dstE(W_dstE2), .W_dstM(W_dstM2)
`ifdef PIPE_MEM_PERF_EN
    , .perf_stall_cnt(perf2)
`endif
  );

  assign busy_s   = sel ? m_busy2  : m_busy0;
  assign mstat_s  = sel ? m_stat2  : m_stat0;
  assign mvalm_s  = sel ? m_valM2  : m_valM0;
  assign wstat_s  = sel ? W_stat2  : W_stat0;
  assign wicode_s = sel ? W_icode2 : W_icode0;
  assign wvale_s  = sel ? W_valE2  : W_valE0;
  assign wvalm_s  = sel ? W_valM2  : W_valM0;
  assign wdstm_s  = sel ? W_dstM2  : W_dstM0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input logic [3:0] ic, input logic [63:0] ve, input logic [63:0] va);
    M_stat  = SAOK;
    M_icode = ic;
    M_valE  = ve;
    M_valA  = va;
    M_dstE  = 4'h4;
    M_dstM  = 4'h2;
  endtask

  task automatic set_nop();
    M_stat  = SAOK;
    M_icode = INOP;
    M_valE  = '0;
    M_valA  = '0;
    M_dstE  = RNONE;
    M_dstM  = RNONE;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    W_stall  = 1'b0;
    W_bubble = 1'b0;
    set_nop();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Wait out the busy cycles, report stage outputs on the issue-complete cycle,
  // then let W capture the instruction and drop M back to a NOP.
  task automatic exec(input logic [3:0] ic, input logic [63:0] ve, input logic [63:0] va,
                      output int nbusy, output logic [63:0] mval, output logic [3:0] mst,
                      output logic [3:0] w_before);
    bit done;
    done  = 1'b0;
    nbusy = 0;
    @(posedge clk);
    #1 set_op(ic, ve, va);
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (busy_s) nbusy++;
      else done = 1'b1;
    end
    if (!done) check("exec_timeout", {63'd0, busy_s}, 64'd0);
    mval     = mvalm_s;
    mst      = mstat_s;
    w_before = wicode_s;
    @(posedge clk);
    #1 set_nop();
  endtask

  initial begin
    int          nb;
    logic [63:0] mv;
    logic [3:0]  ms, wb;
    bit          done;

    sel = 1'b0;
    rst = 1'b1;
    W_stall = 1'b0;
    W_bubble = 1'b0;
    set_nop();
    @(posedge clk);
    @(negedge clk);
    check("rst_icode0", {60'd0, W_icode0}, {60'd0, INOP});
    check("rst_stat2", {60'd0, W_stat2}, {60'd0, SAOK});
    check("rst_dste2", {60'd0, W_dstE2}, {60'd0, RNONE});
    check("rst_busy2", {63'd0, m_busy2}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // ---------------- single-cycle instance ----------------
    exec(IRMMOVQ, 64'h10, 64'hDEAD, nb, mv, ms, wb);
    check("l0_wr_busy", 64'(nb), 64'd0);
    @(negedge clk);
    check("l0_wr_icode", {60'd0, wicode_s}, {60'd0, IRMMOVQ});

    exec(IMRMOVQ, 64'h10, 64'h0, nb, mv, ms, wb);
    check("l0_rd_mvalm", mv, 64'hDEAD);
    check("l0_rd_busy", 64'(nb), 64'd0);
    @(negedge clk);
    check("l0_rd_wvalm", wvalm_s, 64'hDEAD);
    check("l0_rd_dstm", {60'd0, wdstm_s}, 64'h2);

    exec(IRMMOVQ, 64'h08, 64'h1111, nb, mv, ms, wb);
    exec(IRMMOVQ, 64'h0C, 64'hBAD, nb, mv, ms, wb);
    check("l0_misal_mstat", {60'd0, ms}, {60'd0, SADR});
    @(negedge clk);
    check("l0_misal_wstat", {60'd0, wstat_s}, {60'd0, SADR});
    exec(IMRMOVQ, 64'h08, 64'h0, nb, mv, ms, wb);
    @(negedge clk);
    check("l0_misal_nowrite", wvalm_s, 64'h1111);

    exec(IMRMOVQ, 64'h2003, 64'h0, nb, mv, ms, wb);
    @(negedge clk);
    check("l0_oor_wstat", {60'd0, wstat_s}, {60'd0, SADR});
    check("l0_oor_wvalm", wvalm_s, 64'd0);

    exec(IRMMOVQ, 64'h1FF8, 64'h77, nb, mv, ms, wb);
    exec(IPOPQ, 64'h2000, 64'h1FF8, nb, mv, ms, wb);
    @(negedge clk);
    check("l0_pop_wvalm", wvalm_s, 64'h77);
    check("l0_pop_wvale", wvale_s, 64'h2000);
    check("l0_pop_wstat", {60'd0, wstat_s}, {60'd0, SAOK});

    exec(IMRMOVQ, 64'h2000, 64'h0, nb, mv, ms, wb);
    @(negedge clk);
    check("l0_idx_depth", {60'd0, wstat_s}, {60'd0, SADR});

    exec(4'h6, 64'h10, 64'h5, nb, mv, ms, wb);
    @(negedge clk);
    check("l0_opq_wvalm", wvalm_s, 64'd0);
    check("l0_opq_wvale", wvale_s, 64'h10);

    // ---------------- two-cycle instance ----------------
    sel = 1'b1;
    do_reset();
    exec(IRMMOVQ, 64'h40, 64'h1234, nb, mv, ms, wb);
    check("l2_wr_busy", 64'(nb), 64'd2);
    exec(IMRMOVQ, 64'h40, 64'h0, nb, mv, ms, wb);
    check("l2_rd_busy", 64'(nb), 64'd2);
    check("l2_rd_bubble", {60'd0, wb}, {60'd0, INOP});
    @(negedge clk);
    check("l2_rd_icode", {60'd0, wicode_s}, {60'd0, IMRMOVQ});
    check("l2_rd_wvalm", wvalm_s, 64'h1234);

    exec(IMRMOVQ, 64'h2003, 64'h0, nb, mv, ms, wb);
    check("l2_err_busy", 64'(nb), 64'd0);
    @(negedge clk);
    check("l2_err_wstat", {60'd0, wstat_s}, {60'd0, SADR});

    // pushq held in DONE by W_stall
    exec(IRMMOVQ, 64'h80, 64'h0, nb, mv, ms, wb);
    @(posedge clk);
    #1 set_op(IPUSHQ, 64'h80, 64'h5555);
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (!busy_s) done = 1'b1;
    end
    if (!done) check("push_timeout", {63'd0, busy_s}, 64'd0);
    W_stall = 1'b1;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      check("stall_hold_icode", {60'd0, wicode_s}, {60'd0, INOP});
      check("stall_busy", {63'd0, busy_s}, 64'd0);
    end
    W_stall = 1'b0;
    @(posedge clk);
    #1 set_nop();
    @(negedge clk);
    check("stall_rel_icode", {60'd0, wicode_s}, {60'd0, IPUSHQ});
    exec(IMRMOVQ, 64'h80, 64'h0, nb, mv, ms, wb);
    @(negedge clk);
    check("push_readback", wvalm_s, 64'h5555);

    // reset in the middle of a store
    exec(IRMMOVQ, 64'hC0, 64'hAAAA, nb, mv, ms, wb);
    @(posedge clk);
    #1 set_op(IRMMOVQ, 64'hC0, 64'hBBBB);
    @(posedge clk);
    @(negedge clk);
    check("rst_wait_busy", {63'd0, busy_s}, 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    set_nop();
    @(negedge clk);
    check("rst_wait_icode", {60'd0, wicode_s}, {60'd0, INOP});
    check("rst_wait_idle", {63'd0, busy_s}, 64'd0);
    exec(IMRMOVQ, 64'hC0, 64'h0, nb, mv, ms, wb);
    check("rst_rd_busy", 64'(nb), 64'd2);
    @(negedge clk);
    check("rst_nowrite", wvalm_s, 64'hAAAA);

    // bubble injected while the load is waiting
    @(posedge clk);
    #1 set_op(IMRMOVQ, 64'h40, 64'h0);
    @(posedge clk);
    #1 W_bubble = 1'b1;
    @(negedge clk);
    check("bub_busy", {63'd0, busy_s}, 64'd1);
    @(posedge clk);
    #1 W_bubble = 1'b0;
    @(negedge clk);
    check("bub_done", {63'd0, busy_s}, 64'd0);
    @(posedge clk);
    #1 set_nop();
    @(negedge clk);
    check("bub_icode", {60'd0, wicode_s}, {60'd0, IMRMOVQ});
    check("bub_wvalm", wvalm_s, 64'h1234);

`ifdef PIPE_MEM_PERF_EN
    do_reset();
    exec(IMRMOVQ, 64'h40, 64'h0, nb, mv, ms, wb);
    exec(IMRMOVQ, 64'h40, 64'h0, nb, mv, ms, wb);
    @(negedge clk);
    check("perf_lat2", {32'd0, perf2}, 64'd4);
    check("perf_lat0", {32'd0, perf0}, 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipe_mem_stage.md
Name: pipe_mem_stage

Overview:
Parametrised successor of the Y86 pipeline memory stage. It performs data-memory reads and writes for mrmovq, rmmovq, pushq, popq, call and ret. Access latency is configurable, and the block raises a stall request while an access is in flight. It detects out-of-range and misaligned addresses as SADR, and owns the W pipeline register with stall/bubble control. It sits between the M register (execute output) and the write-back stage.

Parameters:
WORD_W, 64, data and address width in bits
DEPTH, 1024, number of WORD_W-bit words in data memory
MEM_LAT, 2, extra cycles per memory access (0 = single-cycle, no stall)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
M_stat  in  4  status from M register
M_icode  in  4  instruction code from M register
M_valE  in  WORD_W  ALU result / memory address
M_valA  in  WORD_W  store data / pop-ret address
M_dstE  in  4  destination register E
M_dstM  in  4  destination register M
W_stall  in  1  hold W register (from pipeline control)
W_bubble  in  1  load NOP into W register
m_stat  out  4  combinational status after memory (forwarded to control)
m_valM  out  WORD_W  read data (forwarded to decode)
m_busy  out  1  access in progress; upstream must hold M stable
W_stat  out  4  W register
W_icode  out  4  W register
W_valE  out  WORD_W  W register
W_valM  out  WORD_W  W register
W_dstE  out  4  W register
W_dstM  out  4  W register

Behaviour:
- Addressing: byte addresses. Read address = M_valA for popq/ret, M_valE otherwise. Write address = M_valE for rmmovq/pushq/call; write data = M_valA. Word index = addr >> 3.
- dmem_error = mem op AND (addr[2:0] != 0 OR index >= DEPTH). On error: m_stat = SADR, no write, m_valM = 0. Otherwise m_stat = M_stat. The error is per-instruction, not sticky.
- Non-memory icodes: m_valM = 0, no access, m_busy = 0.
- FSM states: IDLE, WAIT, DONE.
  - IDLE: a valid, error-free mem op with MEM_LAT > 0 loads counter = MEM_LAT and goes to WAIT.
  - WAIT: m_busy = 1; counter decrements; at 1 go to DONE.
  - DONE: m_busy = 0. The write commits this cycle, or the read data is valid this cycle. Go to IDLE when W is not stalled; otherwise hold DONE with m_busy = 0.
- MEM_LAT = 0: the FSM stays in IDLE. Reads are combinational, writes commit at the posedge when W captures the instruction.
- Error ops take zero stall cycles regardless of MEM_LAT.
- A write commits exactly once per instruction, only in the cycle its result enters W. Memory contents are not cleared by rst.
- W register priority: rst > W_bubble > W_stall > m_busy > load.
  - Bubble / m_busy / rst load: stat = SAOK, icode = INOP, valE = 0, valM = 0, dstE = dstM = RNONE.
  - W_stall holds all W fields.
  - Load captures m_stat, M_icode, M_valE, m_valM, M_dstE, M_dstM.
- Reset values: all W outputs as bubble; FSM = IDLE; counter = 0; m_busy = 0.
- rst mid-access: abandon immediately; no write is performed.
- W_bubble during WAIT: W gets a bubble and the access continues.
- W_stall asserted in the DONE cycle: the access is not repeated, and read data is held internally until the load.

Optional Feature:
PIPE_MEM_PERF_EN
- Defined: adds output perf_stall_cnt [31:0], incremented each cycle m_busy = 1. It is cleared by rst and saturates at 0xFFFFFFFF.
- Undefined: the port and counter are absent. Behaviour is otherwise identical.

Decomposition:
- Package y86_pkg: icode constants (INOP=1, IRMMOVQ=4, IMRMOVQ=5, ICALL=8, IRET=9, IPUSHQ=A, IPOPQ=B), stat constants (SAOK=1, SHLT=2, SADR=3, SINS=4), RNONE=F, FSM state enum.
- Sub-module dmem_array: DEPTH x WORD_W memory with one sync write port and one combinational read port.

Test Plan:
- MEM_LAT=0: rmmovq M_valE=0x10, M_valA=0xDEAD, then mrmovq M_valE=0x10 -> W_valM=0xDEAD on the next cycle, m_busy never high.
- MEM_LAT=2: mrmovq -> m_busy high for 2 cycles, W gets 2 bubbles (icode=1), then W_icode=5 with correct W_valM.
- mrmovq with M_valE=0x2003 (DEPTH=1024) -> W_stat=3, W_valM=0, m_busy=0. rmmovq to 0x0C -> SADR, memory unchanged.
- W_stall=1 during DONE of pushq -> W held; memory written exactly once after stall release, verified by readback.
- rst in WAIT of rmmovq -> W is bubble next cycle, FSM IDLE, target word unchanged.
- PIPE_MEM_PERF_EN, MEM_LAT=3, two loads -> perf_stall_cnt=6.
